// File: rtl/ccip_rd_arbiter_if.sv
// Bundle of the requester-side and CCI-P c0 read-channel signals shared by the read arbiter.
// slave is the arbiter's view; master is the AFU/bench view.
interface ccip_rd_arbiter_if #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned ADDR_W  = 42,
  parameter int unsigned DATA_W  = 512,
  parameter int unsigned MDATA_W = 16
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ-1:0]        req_grant;
  logic                    tx_valid;
  logic [ADDR_W-1:0]       tx_addr;
  logic [MDATA_W-1:0]      tx_mdata;
  logic                    tx_alm_full;
  logic                    rx_rsp_valid;
  logic [MDATA_W-1:0]      rx_mdata;
  logic [DATA_W-1:0]       rx_data;
  logic [N_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]       rsp_data;
  logic [7:0]              outstanding;
  logic                    flush_req;
  logic                    flush_done;
  logic                    err;

  modport slave (
    input  req_valid, req_addr, tx_alm_full, rx_rsp_valid, rx_mdata, rx_data, flush_req,
    output req_grant, tx_valid, tx_addr, tx_mdata, rsp_valid, rsp_data, outstanding,
           flush_done, err
  );

  modport master (
    output req_valid, req_addr, tx_alm_full, rx_rsp_valid, rx_mdata, rx_data, flush_req,
    input  req_grant, tx_valid, tx_addr, tx_mdata, rsp_valid, rsp_data, outstanding,
           flush_done, err
  );
endinterface

// File: rtl/ccip_rd_arbiter.sv
// Round-robin arbiter sharing the CCI-P c0 read channel; tags mdata with the requester index,
// routes responses back by that index, and supports a flush/drain handshake.
module ccip_rd_arbiter #(
  parameter int unsigned N_REQ           = 4,
  parameter int unsigned MAX_OUTSTANDING = 16,
  parameter int unsigned ADDR_W          = 42,
  parameter int unsigned DATA_W          = 512,
  parameter int unsigned MDATA_W         = 16
) (
  input logic               i_clk,
  input logic               i_reset,
  ccip_rd_arbiter_if.slave  io_bus
);
  localparam int unsigned IDX_W = (N_REQ > 2) ? $clog2(N_REQ) : 1;
  localparam int unsigned TAG_W = MDATA_W - IDX_W;

  typedef enum logic [1:0] {StRun, StDrain, StDone} state_e;

  state_e             r_state, w_state_d;
  logic [IDX_W-1:0]   r_rr_ptr, w_rr_ptr_d, w_cand, w_gnt_idx;
  logic [N_REQ-1:0]   w_grant;
  logic               w_gnt_found, w_can_issue;
  logic [ADDR_W-1:0]  w_gnt_addr;
  logic [TAG_W-1:0]   r_tag;
  logic               r_tx_valid;
  logic [ADDR_W-1:0]  r_tx_addr;
  logic [MDATA_W-1:0] r_tx_mdata;
  logic [N_REQ-1:0]   r_rsp_valid;
  logic [DATA_W-1:0]  r_rsp_data;
  logic [7:0]         r_outstanding, w_outstanding_d;
  logic               r_err;
  logic [IDX_W-1:0]   w_rx_idx;
  logic               w_rx_idx_ok, w_rx_route, w_rx_err;
  logic               w_unused_mdata;

  assign w_can_issue = (r_state == StRun) && !io_bus.tx_alm_full &&
                       (r_outstanding < 8'(MAX_OUTSTANDING));

  // First requesting index at or after rr_ptr, wrapping around.
  always_comb begin
    w_grant     = '0;
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    w_cand      = '0;
    if (w_can_issue) begin
      for (int unsigned k = 0; k < N_REQ; k++) begin
        w_cand = IDX_W'((32'(r_rr_ptr) + k) % N_REQ);
        if (!w_gnt_found && io_bus.req_valid[w_cand]) begin
          w_gnt_found = 1'b1;
          w_gnt_idx   = w_cand;
        end
      end
    end
    if (w_gnt_found) w_grant[w_gnt_idx] = 1'b1;
  end

  always_comb begin
    w_gnt_addr = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) w_gnt_addr = io_bus.req_addr[i*ADDR_W +: ADDR_W];
    end
  end

  assign w_rr_ptr_d = w_gnt_found ? IDX_W'((32'(w_gnt_idx) + 1) % N_REQ) : r_rr_ptr;

  assign w_rx_idx       = io_bus.rx_mdata[IDX_W-1:0];
  assign w_rx_idx_ok    = 32'(w_rx_idx) < N_REQ;
  // A response with nothing in flight is stale (e.g. from before a reset) and is dropped.
  assign w_rx_route     = io_bus.rx_rsp_valid && w_rx_idx_ok && (r_outstanding != 8'd0);
  assign w_rx_err       = io_bus.rx_rsp_valid && (!w_rx_idx_ok || (r_outstanding == 8'd0));
  assign w_unused_mdata = ^io_bus.rx_mdata;

  always_comb begin
    w_outstanding_d = r_outstanding;
    if (w_gnt_found && !io_bus.rx_rsp_valid) begin
      w_outstanding_d = r_outstanding + 8'd1;
    end else if (!w_gnt_found && io_bus.rx_rsp_valid && (r_outstanding != 8'd0)) begin
      w_outstanding_d = r_outstanding - 8'd1;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StRun:   if (io_bus.flush_req) w_state_d = StDrain;
      StDrain: if (w_outstanding_d == 8'd0) w_state_d = StDone;
      StDone:  w_state_d = StRun;
      default: w_state_d = StRun;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= StRun;
      r_rr_ptr      <= '0;
      r_tag         <= '0;
      r_tx_valid    <= 1'b0;
      r_tx_addr     <= '0;
      r_tx_mdata    <= '0;
      r_rsp_valid   <= '0;
      r_rsp_data    <= '0;
      r_outstanding <= 8'd0;
      r_err         <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_rr_ptr      <= w_rr_ptr_d;
      r_outstanding <= w_outstanding_d;
      r_tx_valid    <= w_gnt_found;
      if (w_gnt_found) begin
        r_tx_addr  <= w_gnt_addr;
        r_tx_mdata <= {r_tag, w_gnt_idx};
        r_tag      <= r_tag + 1'b1;
      end
      r_rsp_valid <= '0;
      if (w_rx_route) begin
        r_rsp_valid[w_rx_idx] <= 1'b1;
        r_rsp_data            <= io_bus.rx_data;
      end
      if (w_rx_err) r_err <= 1'b1;
    end
  end

  assign io_bus.req_grant   = w_grant;
  assign io_bus.tx_valid    = r_tx_valid;
  assign io_bus.tx_addr     = r_tx_addr;
  assign io_bus.tx_mdata    = r_tx_mdata;
  assign io_bus.rsp_valid   = r_rsp_valid;
  assign io_bus.rsp_data    = r_rsp_data;
  assign io_bus.outstanding = r_outstanding;
  assign io_bus.flush_done  = (r_state == StDone);
  assign io_bus.err         = r_err;
endmodule

// File: tb/tb_ccip_rd_arbiter.sv
// Directed bench for ccip_rd_arbiter: expected c0 requests and routed responses are queued
// when stimulus is driven and compared when the DUT produces them.
module tb_ccip_rd_arbiter;
  localparam int unsigned NR = 4;
  localparam int unsigned AW = 42;
  localparam int unsigned DW = 512;
  localparam int unsigned MW = 16;

  typedef struct {
    int            due;
    logic [AW-1:0] addr;
    logic [MW-1:0] mdata;
  } tx_exp_t;

  typedef struct {
    int            due;
    logic [NR-1:0] vld;
    logic [DW-1:0] data;
  } rsp_exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [13:0] tag_m;
  logic [AW-1:0] addr_tb [NR];
  tx_exp_t  tx_q[$];
  rsp_exp_t rsp_q[$];

  always #5 clk = ~clk;

  ccip_rd_arbiter_if #(.N_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .MDATA_W(MW)) bus ();

  ccip_rd_arbiter #(
    .N_REQ(NR), .MAX_OUTSTANDING(16), .ADDR_W(AW), .DATA_W(DW), .MDATA_W(MW)
  ) dut (
    .i_clk  (clk),
    .i_reset(reset),
    .io_bus (bus)
  );

  task automatic check(input string nm, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
    end
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    addr_tb[i] = a;
    bus.req_addr[i*AW +: AW] = a;
  endtask

  // Checks the combinational grant, queues the c0 request it implies, then advances a cycle.
  task automatic step(input string nm, input logic [NR-1:0] exp_g);
    tx_exp_t e;
    @(negedge clk);
    check(nm, bus.req_grant, exp_g);
    for (int i = 0; i < NR; i++) begin
      if (exp_g[i]) begin
        e.due   = cyc + 1;
        e.addr  = addr_tb[i];
        e.mdata = {tag_m, 2'(i)};
        tx_q.push_back(e);
        tag_m++;
      end
    end
    @(posedge clk);
    #1;
    bus.rx_rsp_valid = 1'b0;
    bus.flush_req    = 1'b0;
  endtask

  task automatic send_rsp(input logic [MW-1:0] md, input logic [DW-1:0] d);
    bus.rx_rsp_valid = 1'b1;
    bus.rx_mdata     = md;
    bus.rx_data      = d;
  endtask

  task automatic exp_rsp(input int idx, input logic [DW-1:0] d);
    rsp_exp_t r;
    r.due      = cyc + 1;
    r.vld      = '0;
    r.vld[idx] = 1'b1;
    r.data     = d;
    rsp_q.push_back(r);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.req_valid = '0;
    bus.rx_rsp_valid = 1'b0;
    bus.flush_req = 1'b0;
    bus.tx_alm_full = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    tag_m = '0;
  endtask

  initial begin
    bus.req_valid    = '0;
    bus.req_addr     = '0;
    bus.tx_alm_full  = 1'b0;
    bus.rx_rsp_valid = 1'b0;
    bus.rx_mdata     = '0;
    bus.rx_data      = '0;
    bus.flush_req    = 1'b0;
    tag_m            = '0;
    for (int i = 0; i < NR; i++) addr_tb[i] = '0;

    fork
      begin : monitor
        tx_exp_t  te;
        rsp_exp_t re;
        forever begin
          @(posedge clk);
          cyc++;
          @(negedge clk);
          if (tx_q.size() > 0 && tx_q[0].due == cyc) begin
            te = tx_q.pop_front();
            check("tx_valid", bus.tx_valid, 1);
            check("tx_addr", bus.tx_addr, te.addr);
            check("tx_mdata", bus.tx_mdata, te.mdata);
          end else if (bus.tx_valid) begin
            check("tx_spurious", bus.tx_valid, 0);
          end
          if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
            re = rsp_q.pop_front();
            check("rsp_valid", bus.rsp_valid, re.vld);
            check("rsp_data", bus.rsp_data, re.data);
          end else if (|bus.rsp_valid) begin
            check("rsp_spurious", bus.rsp_valid, 0);
          end
        end
      end
    join_none

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_tx_valid", bus.tx_valid, 0);
    check("rst_tx_addr", bus.tx_addr, 0);
    check("rst_tx_mdata", bus.tx_mdata, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_outstanding", bus.outstanding, 0);
    check("rst_flush_done", bus.flush_done, 0);
    check("rst_err", bus.err, 0);
    reset = 1'b0;

    // Single request and its response
    set_addr(2, 42'h100);
    bus.req_valid = 4'b0100;
    step("single_grant", 4'b0100);
    bus.req_valid = '0;
    step("single_idle", 4'b0000);
    check("single_out", bus.outstanding, 1);
    send_rsp(16'h0002, 512'hAB);
    exp_rsp(2, 512'hAB);
    step("single_rsp", 4'b0000);
    check("single_out_after", bus.outstanding, 0);
    step("single_rsp_idle", 4'b0000);
    check("single_err", bus.err, 0);

    // Fairness, then fill to the outstanding limit
    do_reset();
    for (int i = 0; i < NR; i++) set_addr(i, 42'h1000 + 42'(i));
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) step("fair_grant", 4'(1 << (k % 4)));
    check("fair_out", bus.outstanding, 8);
    for (int k = 0; k < 8; k++) step("fill_grant", 4'(1 << (k % 4)));
    check("fill_out", bus.outstanding, 16);
    step("limit_grant", 4'b0000);
    step("limit_grant", 4'b0000);
    check("limit_out", bus.outstanding, 16);
    send_rsp(16'h0000, 512'h11);
    exp_rsp(0, 512'h11);
    step("limit_rsp_nogrant", 4'b0000);
    check("limit_rsp_out", bus.outstanding, 15);
    step("freed_grant", 4'b0001);
    check("freed_out", bus.outstanding, 16);
    send_rsp(16'h0005, 512'h22);
    exp_rsp(1, 512'h22);
    step("limit_rsp2", 4'b0000);
    send_rsp(16'h000A, 512'h33);
    exp_rsp(2, 512'h33);
    step("simul_grant", 4'b0010);
    check("simul_out", bus.outstanding, 15);
    bus.tx_alm_full = 1'b1;
    repeat (5) step("almfull_grant", 4'b0000);
    bus.tx_alm_full = 1'b0;
    check("almfull_out", bus.outstanding, 15);
    step("almfull_off_grant", 4'b0100);
    bus.req_valid = '0;
    step("fill_idle", 4'b0000);
    check("fill_end_out", bus.outstanding, 16);

    // Flush with three reads in flight
    do_reset();
    for (int i = 0; i < NR; i++) set_addr(i, 42'h2000 + 42'(i));
    bus.req_valid = 4'b0111;
    step("fl_grant0", 4'b0001);
    step("fl_grant1", 4'b0010);
    bus.flush_req = 1'b1;
    step("fl_grant2", 4'b0100);
    check("fl_out", bus.outstanding, 3);
    step("drain1", 4'b0000);
    send_rsp(16'h0000, 512'hC0);
    exp_rsp(0, 512'hC0);
    step("drain2", 4'b0000);
    bus.flush_req = 1'b1;
    step("drain3", 4'b0000);
    send_rsp(16'h0005, 512'hC1);
    exp_rsp(1, 512'hC1);
    step("drain4", 4'b0000);
    check("drain_flush_done", bus.flush_done, 0);
    step("drain5", 4'b0000);
    send_rsp(16'h000A, 512'hC2);
    exp_rsp(2, 512'hC2);
    step("drain6", 4'b0000);
    check("done_flush_done", bus.flush_done, 1);
    check("done_out", bus.outstanding, 0);
    step("done_nogrant", 4'b0000);
    check("after_flush_done", bus.flush_done, 0);
    step("resume_grant", 4'b0001);
    bus.req_valid = '0;
    step("resume_idle", 4'b0000);

    // Errors: stale response, stickiness, and in-flight response after reset
    do_reset();
    check("err_clear", bus.err, 0);
    send_rsp(16'h0001, 512'hEE);
    step("err_zero_rsp", 4'b0000);
    check("err_set", bus.err, 1);
    check("err_out", bus.outstanding, 0);
    step("err_idle", 4'b0000);
    step("err_idle", 4'b0000);
    check("err_sticky", bus.err, 1);
    do_reset();
    check("err_reset_clear", bus.err, 0);
    set_addr(0, 42'h3000);
    bus.req_valid = 4'b0001;
    step("pre_reset_grant", 4'b0001);
    bus.req_valid = '0;
    step("pre_reset_idle", 4'b0000);
    do_reset();
    check("post_reset_out", bus.outstanding, 0);
    send_rsp(16'h0000, 512'hFF);
    step("post_reset_rsp", 4'b0000);
    check("post_reset_err", bus.err, 1);
    step("post_reset_idle", 4'b0000);
    do_reset();
    check("final_err_clear", bus.err, 0);

    check("tx_q_drained", 512'(tx_q.size()), 0);
    check("rsp_q_drained", 512'(rsp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
